input_conditioner: RTL
======================

Name: input_conditioner

Overview:
- Parametrised, multi-channel successor to the single-line debounce block in the top level.
- Synchronises N asynchronous inputs (reset button, switches, i_button, GPIO inputs) into the CPU clock domain and debounces each channel independently.
- Emits clean levels plus one-cycle rise and fall pulses for the arbiter and peripherals.
- An optional interrupt aggregator drives the CPU int/int_ack handshake.

Parameters:
- CHANNELS, 8, number of independent input channels (>=1)
- SYNC_STAGES, 2, synchroniser flops per channel (>=2)
- DEBOUNCE_CYCLES, 250000, consecutive stable clocks required to accept a new level (>=1; 10 ms at 25 MHz)
- INIT, 0, CHANNELS-bit reset value of synchroniser, level and debounce state per channel

Ports:
- clk  in  1  system clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- din  in  CHANNELS  raw asynchronous inputs
- level  out  CHANNELS  debounced level
- rise  out  CHANNELS  one-cycle pulse on accepted 0->1
- fall  out  CHANNELS  one-cycle pulse on accepted 1->0
- any_change  out  1  OR of all rise|fall
- irq_mask  in  CHANNELS  1 = channel may raise interrupt (feature only)
- int_ack  in  1  clears all pending bits (feature only)
- int  out  1  interrupt request to CPU (feature only)
- pending  out  CHANNELS  sticky edge flags (feature only)

Behaviour:
- Reset (async assert, sync release): all synchroniser stages and level = INIT; counters = 0; rise, fall, any_change, int, pending = 0.
  - No pulse is generated at reset release, even if din differs from INIT; that channel debounces normally afterwards.
- Synchroniser: SYNC_STAGES-deep shift per channel; s = last stage.
- Debounce state, per channel, counter width $clog2(DEBOUNCE_CYCLES+1):
  - If s == level: counter <= 0. Any single-cycle glitch fully restarts the count.
  - If s != level and counter == DEBOUNCE_CYCLES-1: level <= s, counter <= 0, and the matching rise/fall register is set for exactly one cycle.
  - Otherwise: counter <= counter + 1.
- Latency: din changes before edge 1 and is held. Then level and the pulse both change after edge SYNC_STAGES + DEBOUNCE_CYCLES, and the pulse drops one cycle later.
- Counter never wraps: the maximum value reached is DEBOUNCE_CYCLES-1.
- rise/fall are registered and mutually exclusive per channel. Multiple channels may pulse in the same cycle.
- any_change is registered in the same cycle as the pulses.
- Input held at a new value for DEBOUNCE_CYCLES-1 stable cycles and then reverting: no level change and no pulse.

Optional Feature:
- INCOND_IRQ_EN defined:
  - pending[i] is set on the cycle rise[i]|fall[i] is high while irq_mask[i]=1.
  - int_ack=1 clears all pending bits on the next edge. If a new masked edge coincides with int_ack, that bit stays set (set wins).
  - int = |pending, registered, asserted the cycle after pending becomes non-zero.
  - Clearing irq_mask does not clear existing pending bits.
- INCOND_IRQ_EN undefined:
  - int and pending are tied to 0; irq_mask and int_ack are ignored.
  - No pending or int flops are synthesised; ports remain for a stable interface.

Test Plan:
- Parameters CHANNELS=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, INIT=0 unless noted.
- Reset value: INIT=4'b1010, rst pulse with din=4'b0000 -> level=4'b1010 during and after reset; no rise/fall at release; level reaches 4'b0000 and fall=4'b1010 for one cycle exactly 6 edges after release.
- Clean edge: din[0] 0->1 held -> level[0]=1 and rise=4'b0001 after edge 6, rise low after edge 7, any_change mirrors rise; counter never exceeds 3.
- Bounce rejection: din[1] high for 3 cycles, low 1, high 3, low -> level[1] stays 0, no pulses; then hold high 4+ cycles -> rise[1] once.
- Simultaneous channels: din 4'b0000->4'b0110 in one cycle -> rise=4'b0110 in a single cycle; then 4'b0100 held -> fall=4'b0010 only.
- Mid-count reset: din[2] high, assert rst after 3 edges -> level=0, counter=0, no pulse; after release, full 6-edge latency before rise[2].
- IRQ (INCOND_IRQ_EN, irq_mask=4'b0001):
  - Edges on channels 0 and 3 -> pending=4'b0001, int=1 one cycle later.
  - int_ack in the same cycle as a new rise[0] -> pending stays 4'b0001.
  - Lone int_ack -> pending=0, then int=0.
  - Build without the macro -> int stays 0 throughout.

Source files
------------

// File: rtl/input_conditioner_if.sv
// Signal bundle between input_conditioner and its users: raw inputs, conditioned
// levels/edge pulses, and the interrupt handshake.
interface input_conditioner_if #(
  parameter int CHANNELS = 8
);
  logic [CHANNELS-1:0] din_i;
  logic [CHANNELS-1:0] level_o;
  logic [CHANNELS-1:0] rise_o;
  logic [CHANNELS-1:0] fall_o;
  logic                any_change_o;
  logic [CHANNELS-1:0] irq_mask_i;
  logic                int_ack_i;
  logic                int_o;
  logic [CHANNELS-1:0] pending_o;

  modport master (
    output din_i, irq_mask_i, int_ack_i,
    input  level_o, rise_o, fall_o, any_change_o, int_o, pending_o
  );

  modport slave (
    input  din_i, irq_mask_i, int_ack_i,
    output level_o, rise_o, fall_o, any_change_o, int_o, pending_o
  );
endinterface

// File: rtl/input_conditioner.sv
// Multi-channel synchroniser + debouncer with registered rise/fall pulses.
// Optional interrupt aggregator enabled by defining INCOND_IRQ_EN.
module input_conditioner #(
  parameter int                  CHANNELS        = 8,
  parameter int                  SYNC_STAGES     = 2,
  parameter int                  DEBOUNCE_CYCLES = 250000,
  parameter logic [CHANNELS-1:0] INIT            = '0
) (
  input logic                clk,
  input logic                rst,
  input_conditioner_if.slave bus
);
  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q, sync_d;
  logic [CHANNELS-1:0]                  s;
  logic [CHANNELS-1:0]                  level_q, level_d;
  logic [CHANNELS-1:0][CW-1:0]          cnt_q, cnt_d;
  logic [CHANNELS-1:0]                  rise_q, rise_d;
  logic [CHANNELS-1:0]                  fall_q, fall_d;
  logic                                 any_change_q, any_change_d;

  // Stage 0 takes the raw pin; the last stage is the first value safe to use.
  assign sync_d = {sync_q[SYNC_STAGES-2:0], bus.din_i};
  assign s      = sync_q[SYNC_STAGES-1];

  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (s[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        level_d[i] = s[i];
        cnt_d[i]   = '0;
        rise_d[i]  = s[i];
        fall_d[i]  = ~s[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
    any_change_d = |(rise_d | fall_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q       <= {SYNC_STAGES{INIT}};
      level_q      <= INIT;
      cnt_q        <= '0;
      rise_q       <= '0;
      fall_q       <= '0;
      any_change_q <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      level_q      <= level_d;
      cnt_q        <= cnt_d;
      rise_q       <= rise_d;
      fall_q       <= fall_d;
      any_change_q <= any_change_d;
    end
  end

  assign bus.level_o      = level_q;
  assign bus.rise_o       = rise_q;
  assign bus.fall_o       = fall_q;
  assign bus.any_change_o = any_change_q;

`ifdef INCOND_IRQ_EN
  logic [CHANNELS-1:0] pending_q, pending_d;
  logic                int_q;

  // A fresh masked edge wins over a simultaneous acknowledge.
  always_comb begin
    pending_d = bus.int_ack_i ? '0 : pending_q;
    pending_d = pending_d | ((rise_q | fall_q) & bus.irq_mask_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
      int_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      int_q     <= |pending_q;
    end
  end

  assign bus.pending_o = pending_q;
  assign bus.int_o     = int_q;
`else
  logic unused_irq_inputs;
  assign unused_irq_inputs = ^{bus.irq_mask_i, bus.int_ack_i};
  assign bus.pending_o     = '0;
  assign bus.int_o         = 1'b0;
`endif
endmodule
